alert_arbiter: RTL and testbench

- Owns the single shared `indicator` output of the digital clock.
- Arbitrates between alarm-match, timer-expiry and hourly-chime event pulses from the timekeeping datapath.
- Runs each event's output pattern, ring timeout and (optionally) alarm snooze.
- Sits between the clock/alarm/timer counters and the indicator pin, on the 10 Hz system clock.

---
 rtl/alert_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alert_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alert_arbiter.sv
// Shared indicator arbiter for the digital clock: alarm > timer > chime, with ring timeout.
// Optional alarm snooze is built only when ALERT_SNOOZE_EN is defined.
module alert_arbiter #(
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned RING_SECS     = 60,
  parameter int unsigned SNOOZE_SECS   = 300,
  parameter int unsigned CHIME_TICKS   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alarm_req,
  input  logic       timer_req,
  input  logic       chime_req,
  input  logic       stop_in,
  input  logic       snooze_in,
  output logic       indicator,
  output logic [1:0] active_src,
  output logic       snoozing,
  output logic       missed_alarm
);

  localparam int unsigned TickMax = (TICKS_PER_SEC > CHIME_TICKS) ? TICKS_PER_SEC : CHIME_TICKS;
  localparam int unsigned TW      = $clog2(TickMax) + 1;
  localparam int unsigned SW      = $clog2(RING_SECS) + 1;

  localparam logic [TW-1:0] TickLast  = TW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] TickHalf  = TW'(TICKS_PER_SEC / 2);
  localparam logic [TW-1:0] ChimeLast = TW'(CHIME_TICKS - 1);
  localparam logic [SW-1:0] RingSecs  = SW'(RING_SECS);

  // Encoding doubles as the active_src code.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRingAlarm = 2'd1,
    StRingTimer = 2'd2,
    StChime     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          alarm_p_q, alarm_p_d;
  logic          timer_p_q, timer_p_d;
  logic          chime_p_q, chime_p_d;
  logic          missed_q, missed_d;
  logic          indicator_q, indicator_d;
  logic          leave, timeout;
  logic          snooze_go, snz_expire;

`ifdef ALERT_SNOOZE_EN
  localparam int unsigned   ZW         = $clog2(SNOOZE_SECS) + 1;
  localparam logic [ZW-1:0] SnoozeSecs = ZW'(SNOOZE_SECS);

  logic          snoozing_q, snoozing_d;
  logic [TW-1:0] snz_tick_q, snz_tick_d;
  logic [ZW-1:0] snz_sec_q, snz_sec_d;

  assign snooze_go  = (state_q == StRingAlarm) & snooze_in & ~stop_in;
  // Stop or a fresh alarm request pre-empts expiry; the request latches alarm_p on its own.
  assign snz_expire = snoozing_q & ~stop_in & ~alarm_req & (snz_tick_q == TickLast) &
                      (snz_sec_q + 1'b1 == SnoozeSecs);

  always_comb begin : snooze_next
    snoozing_d = snoozing_q;
    snz_tick_d = snz_tick_q;
    snz_sec_d  = snz_sec_q;
    if (snooze_go) begin
      snoozing_d = 1'b1;
      snz_tick_d = '0;
      snz_sec_d  = '0;
    end else if (snoozing_q) begin
      if (stop_in || alarm_req || snz_expire) begin
        snoozing_d = 1'b0;
      end else if (snz_tick_q == TickLast) begin
        snz_tick_d = '0;
        if (snz_sec_q != SnoozeSecs) snz_sec_d = snz_sec_q + 1'b1;
      end else begin
        snz_tick_d = snz_tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : snooze_reg
    if (!reset_n) begin
      snoozing_q <= 1'b0;
      snz_tick_q <= '0;
      snz_sec_q  <= '0;
    end else begin
      snoozing_q <= snoozing_d;
      snz_tick_q <= snz_tick_d;
      snz_sec_q  <= snz_sec_d;
    end
  end

  assign snoozing = snoozing_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_in;
  assign snooze_go     = 1'b0;
  assign snz_expire    = 1'b0;
  assign snoozing      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      sec_q       <= '0;
      alarm_p_q   <= 1'b0;
      timer_p_q   <= 1'b0;
      chime_p_q   <= 1'b0;
      missed_q    <= 1'b0;
      indicator_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      sec_q       <= sec_d;
      alarm_p_q   <= alarm_p_d;
      timer_p_q   <= timer_p_d;
      chime_p_q   <= chime_p_d;
      missed_q    <= missed_d;
      indicator_q <= indicator_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    tick_d    = tick_q;
    sec_d     = sec_q;
    // Requests for the source currently being served are merged away.
    alarm_p_d = alarm_p_q | (alarm_req & (state_q != StRingAlarm)) | snz_expire;
    timer_p_d = timer_p_q | (timer_req & (state_q != StRingTimer));
    chime_p_d = chime_p_q | (chime_req & (state_q != StChime));
    missed_d  = missed_q;
    leave     = 1'b0;
    timeout   = 1'b0;

    unique case (state_q)
      StIdle: begin
        leave = 1'b1;
        if (stop_in) missed_d = 1'b0;
      end
      StRingAlarm, StRingTimer: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          if (sec_q != RingSecs) sec_d = sec_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        timeout = (tick_q == TickLast) && (sec_q + 1'b1 == RingSecs);
        leave   = stop_in | timeout | snooze_go;
        if (state_q == StRingAlarm && timeout && !stop_in && !snooze_go) missed_d = 1'b1;
      end
      StChime: begin
        if (tick_q == ChimeLast) leave = 1'b1;
        else tick_d = tick_q + 1'b1;
      end
    endcase

    // Arbitrate on registered pending flags so a request is served one edge after it lands.
    if (leave) begin
      tick_d = '0;
      sec_d  = '0;
      if (alarm_p_q) begin
        state_d   = StRingAlarm;
        alarm_p_d = 1'b0;
      end else if (timer_p_q) begin
        state_d   = StRingTimer;
        timer_p_d = 1'b0;
      end else if (chime_p_q) begin
        state_d   = StChime;
        chime_p_d = 1'b0;
      end else begin
        state_d   = StIdle;
      end
    end
  end

  always_comb begin : output_dec
    indicator_d = 1'b0;
    unique case (state_d)
      StIdle:      indicator_d = 1'b0;
      StRingAlarm: indicator_d = 1'b1;
      StRingTimer: indicator_d = (tick_d < TickHalf);
      StChime:     indicator_d = 1'b1;
    endcase
  end

  assign indicator    = indicator_q;
  assign active_src   = state_q;
  assign missed_alarm = missed_q;

endmodule

// File: tb/tb_alert_arbiter.sv
// Directed self-checking bench for alert_arbiter; snooze cases run when ALERT_SNOOZE_EN is defined.
module tb_alert_arbiter;

  localparam int unsigned Tps = 10, Ring = 60, Snz = 5, Chime = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       alarm_req = 1'b0, timer_req = 1'b0, chime_req = 1'b0;
  logic       stop_in = 1'b0, snooze_in = 1'b0;
  logic       indicator, snoozing, missed_alarm;
  logic [1:0] active_src;

  int checks = 0;
  int errors = 0;

  alert_arbiter #(
    .TICKS_PER_SEC(Tps),
    .RING_SECS    (Ring),
    .SNOOZE_SECS  (Snz),
    .CHIME_TICKS  (Chime)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alarm_req   (alarm_req),
    .timer_req   (timer_req),
    .chime_req   (chime_req),
    .stop_in     (stop_in),
    .snooze_in   (snooze_in),
    .indicator   (indicator),
    .active_src  (active_src),
    .snoozing    (snoozing),
    .missed_alarm(missed_alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ind, input logic [1:0] src,
                            input logic snz, input logic mis);
    check({tag, ".indicator"}, 32'(indicator), 32'(ind));
    check({tag, ".active_src"}, 32'(active_src), 32'(src));
    check({tag, ".snoozing"}, 32'(snoozing), 32'(snz));
    check({tag, ".missed"}, 32'(missed_alarm), 32'(mis));
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse alarm_req and land on the edge where the ring starts.
  task automatic start_alarm();
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    step();
  endtask

  initial begin
    step(2);
    check_outs("reset", 1'b0, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(2);
    check_outs("idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Alarm: pending one edge, ringing the next, dropped on the stop edge.
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    check("alarm_pending_src", 32'(active_src), 32'd0);
    step();
    check_outs("alarm_ring", 1'b1, 2'd1, 1'b0, 1'b0);
    step(10);
    check("alarm_steady_ind", 32'(indicator), 32'd1);
`ifndef ALERT_SNOOZE_EN
    snooze_in = 1'b1;
    step();
    snooze_in = 1'b0;
    check_outs("snooze_ignored", 1'b1, 2'd1, 1'b0, 1'b0);
`endif
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    check_outs("alarm_stop", 1'b0, 2'd0, 1'b0, 1'b0);

    // Timer and chime together: timer first with 5/5 blink, then 3-cycle chime.
    timer_req = 1'b1;
    chime_req = 1'b1;
    step();
    timer_req = 1'b0;
    chime_req = 1'b0;
    step();
    check_outs("timer_entry", 1'b1, 2'd2, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step();
      check($sformatf("timer_blink%0d", i), 32'(indicator), (i < 5) ? 32'd1 : 32'd0);
    end
    stop_in = 1'b1;
    step();
    check_outs("chime_c0", 1'b1, 2'd3, 1'b0, 1'b0);
    step();  // stop still high: no effect in CHIME
    stop_in = 1'b0;
    check_outs("chime_c1", 1'b1, 2'd3, 1'b0, 1'b0);
    step();
    check_outs("chime_c2", 1'b1, 2'd3, 1'b0, 1'b0);
    step();
    check_outs("chime_done", 1'b0, 2'd0, 1'b0, 1'b0);

    // Alarm during timer ring waits; stop hands over on the same edge.
    timer_req = 1'b1;
    step();
    timer_req = 1'b0;
    step();
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    check("no_preempt_src", 32'(active_src), 32'd2);
    step(4);
    check("no_preempt_later", 32'(active_src), 32'd2);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    check_outs("handover_alarm", 1'b1, 2'd1, 1'b0, 1'b0);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    step();
    check_outs("handover_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Alarm left to time out after 600 cycles sets missed_alarm.
    start_alarm();
    step(599);
    check_outs("alarm_last_cycle", 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    check_outs("alarm_timeout", 1'b0, 2'd0, 1'b0, 1'b1);
    step(3);
    check("missed_sticky", 32'(missed_alarm), 32'd1);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    check("missed_cleared", 32'(missed_alarm), 32'd0);

    // Timeout and stop on the same edge counts as a stop.
    start_alarm();
    step(599);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    check_outs("timeout_with_stop", 1'b0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a timer ring.
    timer_req = 1'b1;
    step();
    timer_req = 1'b0;
    step(4);
    check("pre_reset_timer", 32'(active_src), 32'd2);
    reset_n = 1'b0;
    #1;
    check_outs("reset_mid_timer", 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    step();
    check_outs("post_reset_chime", 1'b1, 2'd3, 1'b0, 1'b0);
    step(3);
    check("post_reset_idle", 32'(active_src), 32'd0);

    // Reset also discards a pending request.
    timer_req = 1'b1;
    step();
    timer_req = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step(2);
    check("reset_clears_pending", 32'(active_src), 32'd0);

`ifdef ALERT_SNOOZE_EN
    // Snooze, expire after 5 s (50 cycles), ring again.
    start_alarm();
    snooze_in = 1'b1;
    step();
    snooze_in = 1'b0;
    check_outs("snooze_start", 1'b0, 2'd0, 1'b1, 1'b0);
    step(49);
    check("snooze_running", 32'(snoozing), 32'd1);
    step();
    check_outs("snooze_expire", 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    check_outs("snooze_rering", 1'b1, 2'd1, 1'b0, 1'b0);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;

    // Snooze together with stop: stop wins.
    start_alarm();
    snooze_in = 1'b1;
    stop_in   = 1'b1;
    step();
    snooze_in = 1'b0;
    stop_in   = 1'b0;
    check_outs("snooze_and_stop", 1'b0, 2'd0, 1'b0, 1'b0);
    step(60);
    check("no_rering_after_stop", 32'(active_src), 32'd0);

    // Reset mid-snooze aborts the countdown.
    start_alarm();
    snooze_in = 1'b1;
    step();
    snooze_in = 1'b0;
    step(10);
    check("snooze_before_reset", 32'(snoozing), 32'd1);
    reset_n = 1'b0;
    #1;
    check_outs("reset_mid_snooze", 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    step(60);
    check("no_rering_after_reset", 32'(active_src), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
